// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by both ends of the 7-segment serial display link.
//   - frame_bits(): total bits in one frame (digits x bits per digit)
//   - SEG_0..SEG_9, SEG_BLANK: segment patterns for bits 6:0 (g..a)
//   - DP_BIT, SEG_A_BIT..SEG_G_BIT: bit positions inside one digit byte
//   - seg_to_bcd(): segment pattern to BCD with an invalid flag
package seg7_pkg;

   localparam int DP_BIT    = 7;
   localparam int SEG_A_BIT = 0;
   localparam int SEG_B_BIT = 1;
   localparam int SEG_C_BIT = 2;
   localparam int SEG_D_BIT = 3;
   localparam int SEG_E_BIT = 4;
   localparam int SEG_F_BIT = 5;
   localparam int SEG_G_BIT = 6;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Result of decoding one digit; invalid is set for blank or unknown patterns.
   typedef struct packed {
      logic       invalid;
      logic [3:0] bcd;
   } bcd_dec_t;

   function automatic int frame_bits(input int num_digits, input int bits_per_digit);
      return num_digits * bits_per_digit;
   endfunction

   // The dp bit is not part of the argument, so it can never affect the decode.
   function automatic bcd_dec_t seg_to_bcd(input logic [6:0] seg);
      bcd_dec_t r;
      r.invalid = 1'b0;
      case (seg)
         SEG_0:   r.bcd = 4'd0;
         SEG_1:   r.bcd = 4'd1;
         SEG_2:   r.bcd = 4'd2;
         SEG_3:   r.bcd = 4'd3;
         SEG_4:   r.bcd = 4'd4;
         SEG_5:   r.bcd = 4'd5;
         SEG_6:   r.bcd = 4'd6;
         SEG_7:   r.bcd = 4'd7;
         SEG_8:   r.bcd = 4'd8;
         SEG_9:   r.bcd = 4'd9;
         default: begin
            r.bcd     = 4'hF;
            r.invalid = 1'b1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_sync_edge.sv
// seg7_sync_edge: SYNC_STAGES-deep synchronizer for one asynchronous input,
// followed by a history flop and a registered rising-edge pulse.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_async        : asynchronous input
//   o_level        : synchronized level, delayed to line up with o_rise
//   o_rise         : one-cycle pulse per rising edge of i_async
module seg7_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   r_rise;

   // Synchronizer chain, history flop and registered edge pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync <= {SYNC_STAGES{1'b0}};
         r_hist <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_hist <= r_sync[SYNC_STAGES-1];
         r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
      end
   end

   // r_hist was loaded from the same sample that produced r_rise, so a data
   // line read through o_level is aligned with the clock line's o_rise.
   assign o_level = r_hist;
   assign o_rise  = r_rise;

endmodule

// File: rtl/seg7_serial_rx.sv
// seg7_serial_rx: receive end of the 7-segment serial display link.
// Samples the asynchronous data/clock/latch trio in the i_clk domain, shifts
// data MSB first on serial clock rising edges and commits the frame on a latch
// rising edge when exactly FRAME_BITS bits arrived.
//   i_clk, i_reset      : system clock, asynchronous active-high reset
//   i_serial_data/clk/latch : asynchronous serial link inputs
//   o_digits            : committed frame, digit k at [8k+7:8k]
//   o_frame_valid       : one-cycle pulse on a good commit
//   o_frame_err         : one-cycle pulse on a latch with the wrong bit count
//   o_bit_count         : bits shifted since the last latch (saturates at FRAME_BITS+1)
// Optional macro SEG7_RX_BCD_DECODE_EN adds o_bcd / o_bcd_invalid, decoded
// from the committed frame.
module seg7_serial_rx
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int BITS_PER_DIGIT = 8,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                                             i_clk,
   input  logic                                             i_reset,
   input  logic                                             i_serial_data,
   input  logic                                             i_serial_clk,
   input  logic                                             i_serial_latch,
   output logic [NUM_DIGITS*BITS_PER_DIGIT-1:0]             o_digits,
   output logic                                             o_frame_valid,
   output logic                                             o_frame_err,
   output logic [$clog2(NUM_DIGITS*BITS_PER_DIGIT+2)-1:0]   o_bit_count
`ifdef SEG7_RX_BCD_DECODE_EN
   ,
   output logic [NUM_DIGITS*4-1:0]                          o_bcd,
   output logic [NUM_DIGITS-1:0]                            o_bcd_invalid
`endif
);

   localparam int FRAME_BITS = frame_bits(NUM_DIGITS, BITS_PER_DIGIT);
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);

   logic                  w_data_level;
   logic                  w_sclk_rise;
   logic                  w_latch_rise;
   logic                  w_unused_data_rise;
   logic                  w_unused_sclk_level;
   logic                  w_unused_latch_level;

   logic [FRAME_BITS-1:0] r_shift;
   logic [CNT_W-1:0]      r_bit_count;
   logic [FRAME_BITS-1:0] r_digits;
   logic                  r_frame_valid;
   logic                  r_frame_err;

   logic [FRAME_BITS-1:0] w_shift_next;
   logic [CNT_W-1:0]      w_count_shifted;
   logic [CNT_W-1:0]      w_count_next;
   logic                  w_frame_good;
   logic                  w_frame_bad;

   seg7_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (i_serial_data),
      .o_level (w_data_level),
      .o_rise  (w_unused_data_rise)
   );

   seg7_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (i_serial_clk),
      .o_level (w_unused_sclk_level),
      .o_rise  (w_sclk_rise)
   );

   seg7_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (i_serial_latch),
      .o_level (w_unused_latch_level),
      .o_rise  (w_latch_rise)
   );

   // Shift first, then judge the latch: a serial clock edge in the same cycle
   // as the latch edge is counted and included in the committed data.
   always_comb begin
      w_shift_next    = r_shift;
      w_count_shifted = r_bit_count;
      if (w_sclk_rise) begin
         w_shift_next = {r_shift[FRAME_BITS-2:0], w_data_level};
         if (r_bit_count != CNT_OVR) begin
            w_count_shifted = r_bit_count + CNT_W'(1);
         end else begin
            w_count_shifted = r_bit_count;
         end
      end else begin
         w_shift_next    = r_shift;
         w_count_shifted = r_bit_count;
      end
      w_frame_good = w_latch_rise & (w_count_shifted == CNT_FULL);
      w_frame_bad  = w_latch_rise & (w_count_shifted != CNT_FULL);
      if (w_latch_rise) begin
         w_count_next = {CNT_W{1'b0}};
      end else begin
         w_count_next = w_count_shifted;
      end
   end

   // Shift register, bit counter, committed frame and status pulses.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_shift       <= {FRAME_BITS{1'b0}};
         r_bit_count   <= {CNT_W{1'b0}};
         r_digits      <= {FRAME_BITS{1'b0}};
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_shift       <= w_shift_next;
         r_bit_count   <= w_count_next;
         r_frame_valid <= w_frame_good;
         r_frame_err   <= w_frame_bad;
         if (w_frame_good) begin
            r_digits <= w_shift_next;
         end else begin
            r_digits <= r_digits;
         end
      end
   end

   assign o_digits      = r_digits;
   assign o_frame_valid = r_frame_valid;
   assign o_frame_err   = r_frame_err;
   assign o_bit_count   = r_bit_count;

`ifdef SEG7_RX_BCD_DECODE_EN
   logic [NUM_DIGITS*4-1:0] w_bcd_next;
   logic [NUM_DIGITS-1:0]   w_bcd_inv_next;
   logic [NUM_DIGITS*4-1:0] r_bcd;
   logic [NUM_DIGITS-1:0]   r_bcd_invalid;

   // Decode the frame about to be committed, one digit at a time (dp dropped).
   always_comb begin
      w_bcd_next     = {(NUM_DIGITS*4){1'b0}};
      w_bcd_inv_next = {NUM_DIGITS{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         {w_bcd_inv_next[k], w_bcd_next[k*4 +: 4]} =
            seg_to_bcd(w_shift_next[k*BITS_PER_DIGIT +: 7]);
      end
   end

   // BCD outputs follow o_digits: loaded only on a good commit.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_bcd         <= {(NUM_DIGITS*4){1'b0}};
         r_bcd_invalid <= {NUM_DIGITS{1'b0}};
      end else if (w_frame_good) begin
         r_bcd         <= w_bcd_next;
         r_bcd_invalid <= w_bcd_inv_next;
      end else begin
         r_bcd         <= r_bcd;
         r_bcd_invalid <= r_bcd_invalid;
      end
   end

   assign o_bcd         = r_bcd;
   assign o_bcd_invalid = r_bcd_invalid;
`endif

endmodule

// File: tb/tb_seg7_serial_rx.sv
// tb_seg7_serial_rx: directed bench for seg7_serial_rx. A frame-level model
// (bit list, bit count, commit rule, 4-cycle output latency) drives a
// per-cycle compare of o_digits / o_frame_valid / o_frame_err; literal
// expectations pin the model at key points.
`timescale 1ns/1ps
module tb_seg7_serial_rx;

   localparam int FB = 48;
   localparam logic [47:0] F1 = 48'h065B4F666D7D;   // 12:34:56
   localparam logic [47:0] F2 = 48'h6F7F077D6D4F;   // 98:76:53, last bit is 1
   localparam logic [47:0] F3 = 48'h005B4F666D7D;   // blank:2:34:56
   localparam logic [6:0]  SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        rst;
   logic        sdata;
   logic        sclk;
   logic        slatch;
   logic [47:0] o_digits;
   logic        o_frame_valid;
   logic        o_frame_err;
   logic [5:0]  o_bit_count;
`ifdef SEG7_RX_BCD_DECODE_EN
   logic [23:0] o_bcd;
   logic [5:0]  o_bcd_invalid;
`endif

   seg7_serial_rx dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_serial_data  (sdata),
      .i_serial_clk   (sclk),
      .i_serial_latch (slatch),
      .o_digits       (o_digits),
      .o_frame_valid  (o_frame_valid),
      .o_frame_err    (o_frame_err),
      .o_bit_count    (o_bit_count)
`ifdef SEG7_RX_BCD_DECODE_EN
      ,
      .o_bcd          (o_bcd),
      .o_bcd_invalid  (o_bcd_invalid)
`endif
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   logic [47:0] m_shift = 48'h0;
   int          m_count = 0;
   logic [47:0] pend_digits = 48'h0;
   int          valid_at = -1;
   int          err_at = -1;
   logic [47:0] exp_digits = 48'h0;
   logic [23:0] exp_bcd = 24'h0;
   logic [5:0]  exp_inv = 6'h0;
   int          n_vseen = 0;
   int          n_eseen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Digit decode by table lookup: returns {invalid, bcd}
   function automatic logic [4:0] model_bcd(input logic [6:0] s);
      for (int i = 0; i < 10; i++) begin
         if (SEG_TAB[i] == s) return {1'b0, 4'(i)};
      end
      return 5'h1F;
   endfunction

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (rst) begin
         exp_digits = 48'h0;
         exp_bcd    = 24'h0;
         exp_inv    = 6'h0;
      end else begin
         if (cyc == valid_at) begin
            exp_digits = pend_digits;
            for (int d = 0; d < 6; d++) begin
               logic [4:0] r;
               r = model_bcd(pend_digits[d*8 +: 7]);
               exp_bcd[d*4 +: 4] = r[3:0];
               exp_inv[d]        = r[4];
            end
         end
         check("frame_valid", 64'(o_frame_valid), 64'(cyc == valid_at));
         check("frame_err",   64'(o_frame_err),   64'(cyc == err_at));
         check("digits",      64'(o_digits),      64'(exp_digits));
`ifdef SEG7_RX_BCD_DECODE_EN
         check("bcd",         64'(o_bcd),         64'(exp_bcd));
         check("bcd_invalid", 64'(o_bcd_invalid), 64'(exp_inv));
`endif
         if (o_frame_valid) n_vseen++;
         if (o_frame_err)   n_eseen++;
      end
   end

   task automatic model_shift_bit(input logic b);
      m_shift = {m_shift[46:0], b};
      if (m_count < FB + 1) m_count++;
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      sdata = b;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      model_shift_bit(b);
      repeat (3) @(negedge clk);
      sclk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Sends the top n bits of v, MSB first
   task automatic send_bits(input logic [47:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[47 - i]);
   endtask

   // Latch rising edge, optionally coincident with a final serial clock edge
   task automatic latch_rise(input bit coincident, input logic b);
      @(negedge clk);
      if (coincident) begin
         sdata = b;
         repeat (2) @(negedge clk);
         sclk = 1'b1;
         model_shift_bit(b);
      end
      slatch = 1'b1;
      if (m_count == FB) begin
         pend_digits = m_shift;
         valid_at    = cyc + 4;
      end else begin
         err_at = cyc + 4;
      end
      m_count = 0;
      repeat (3) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic latch_fall();
      slatch = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_latch();
      latch_rise(1'b0, 1'b0);
      latch_fall();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      int e0;
      rst = 1'b1; sdata = 1'b0; sclk = 1'b0; slatch = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_digits", 64'(o_digits), 64'h0);
      check("rst_valid",  64'(o_frame_valid), 64'h0);
      check("rst_err",    64'(o_frame_err), 64'h0);
      check("rst_count",  64'(o_bit_count), 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Good frame 12:34:56
      v0 = n_vseen; e0 = n_eseen;
      send_bits(F1, 48);
      check("good_count_pre", 64'(o_bit_count), 64'd48);
      do_latch();
      check("good_digits", 64'(o_digits), 64'(F1));
      check("good_vpulses", 64'(n_vseen - v0), 64'd1);
      check("good_epulses", 64'(n_eseen - e0), 64'd0);
      check("good_count_post", 64'(o_bit_count), 64'd0);
`ifdef SEG7_RX_BCD_DECODE_EN
      check("good_bcd", 64'(o_bcd), 64'h123456);
      check("good_bcd_inv", 64'(o_bcd_invalid), 64'h0);
`endif

      // Short frame: 47 bits
      v0 = n_vseen; e0 = n_eseen;
      send_bits(F2, 47);
      check("short_count_pre", 64'(o_bit_count), 64'd47);
      do_latch();
      check("short_digits", 64'(o_digits), 64'(F1));
      check("short_epulses", 64'(n_eseen - e0), 64'd1);
      check("short_vpulses", 64'(n_vseen - v0), 64'd0);
      check("short_count_post", 64'(o_bit_count), 64'd0);

      // Overrun: 50 bits
      e0 = n_eseen;
      send_bits(F2, 48);
      send_bit(1'b1);
      send_bit(1'b0);
      check("ovr_count_pre", 64'(o_bit_count), 64'd49);
      do_latch();
      check("ovr_digits", 64'(o_digits), 64'(F1));
      check("ovr_epulses", 64'(n_eseen - e0), 64'd1);

      // Coincident 48th serial clock edge and latch edge
      v0 = n_vseen;
      send_bits(F2, 47);
      latch_rise(1'b1, F2[0]);
      latch_fall();
      check("coin_digits", 64'(o_digits), 64'(F2));
      check("coin_bit0", 64'(o_digits[0]), 64'd1);
      check("coin_vpulses", 64'(n_vseen - v0), 64'd1);

      // Latch held high: only the rising edges act
      v0 = n_vseen; e0 = n_eseen;
      latch_rise(1'b0, 1'b0);            // zero bits -> error
      send_bits(F3, 48);                 // shifts while latch stays high
      latch_fall();
      check("high_count", 64'(o_bit_count), 64'd48);
      do_latch();
      check("high_digits", 64'(o_digits), 64'(F3));
      check("high_epulses", 64'(n_eseen - e0), 64'd1);
      check("high_vpulses", 64'(n_vseen - v0), 64'd1);
`ifdef SEG7_RX_BCD_DECODE_EN
      check("blank_bcd", 64'(o_bcd), 64'hF23456);
      check("blank_bcd_inv", 64'(o_bcd_invalid), 64'h20);
`endif

      // Asynchronous reset at bit 20
      send_bits(F2, 20);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_digits", 64'(o_digits), 64'h0);
      check("arst_valid",  64'(o_frame_valid), 64'h0);
      check("arst_err",    64'(o_frame_err), 64'h0);
      check("arst_count",  64'(o_bit_count), 64'h0);
      m_shift = 48'h0; m_count = 0; valid_at = -1; err_at = -1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      v0 = n_vseen;
      send_bits(F1, 48);
      do_latch();
      check("post_rst_digits", 64'(o_digits), 64'(F1));
      check("post_rst_vpulses", 64'(n_vseen - v0), 64'd1);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
